// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and the iteration count.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'd0;
    localparam logic [1:0] MDU_MULT  = 2'd1;
    localparam logic [1:0] MDU_DIVU  = 2'd2;
    localparam logic [1:0] MDU_DIV   = 2'd3;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add for multiply, restoring
// trial-subtract-shift for divide, over a 64-bit {upper, lower} register.
module mdu_step
    import mdu_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  logic        div_mode,
    output logic [63:0] next_acc
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // Multiply keeps the multiplier in the lower half and shifts the running
    // sum down into it; divide shifts the dividend up into the remainder.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        shifted  = {acc[63:32], acc[31]};
        fits     = shifted >= {1'b0, operand};
        diff     = shifted[31:0] - operand;
        next_acc = 64'd0;
        if (div_mode) begin
            if (fits)
                next_acc = {diff, acc[30:0], 1'b1};
            else
                next_acc = {shifted[31:0], acc[30:0], 1'b0};
        end else begin
            next_acc = {sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers. One op takes
// 33 busy cycles: 32 RUN iterations plus one FIX cycle for sign correction.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        hilo_sel,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    mdu_state_t  state;
    mdu_state_t  next_state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] step_acc;
    logic [31:0] operand;
    logic        div_mode;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;
    logic [63:0] prod_fix;
    logic        load_op;
    logic        step_en;
    logic        write_en;
    logic        move_en;
    logic        is_signed;

    mdu_step u_step (
        .acc      (acc),
        .operand  (operand),
        .div_mode (div_mode),
        .next_acc (step_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == 5'(MDU_ITER - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        load_op  = (state == IDLE) && start;
        move_en  = (state == IDLE) && !start;
        step_en  = state == RUN;
        write_en = state == FIX;
    end

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);

    // Both ops work on magnitudes; the signed 0x80000000 / -1 case falls out
    // of this naturally as LO = 0x80000000, HI = 0.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        hi_fix   = prod_fix[63:32];
        lo_fix   = prod_fix[31:0];
        if (div_mode) begin
            lo_fix = div_zero ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
            hi_fix = neg_r ? -acc[63:32] : acc[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 5'd0;
            acc      <= 64'd0;
            operand  <= 32'd0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (load_op) begin
            cnt      <= 5'd0;
            acc      <= {32'd0, is_signed ? abs32(a) : a};
            operand  <= is_signed ? abs32(b) : b;
            div_mode <= op[1];
            neg_q    <= is_signed && (a[31] ^ b[31]);
            neg_r    <= is_signed && a[31];
            div_zero <= op[1] && (b == 32'd0);
        end else if (step_en) begin
            acc <= step_acc;
            cnt <= cnt + 5'd1;
        end else if (write_en) begin
            hi <= hi_fix;
            lo <= lo_fix;
        end else if (move_en) begin
            if (mthi) hi <= a;
            if (mtlo) lo <= a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            done <= 1'b0;
        else
            done <= write_en;
    end

    assign result = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: an independent arithmetic model feeds a
// scoreboard queue that is drained as each op signals done.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        hilo_sel;
    logic [31:0] result;
    logic        busy;
    logic        done;

    logic [63:0] sb[$];
    int          n_checks;
    int          n_fail;

    mdu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .hilo_sel (hilo_sel),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] px, py;
        int          sx, sy;
        case (mop)
            2'd0: return {32'd0, x} * {32'd0, y};
            2'd1: begin
                px = {{32{x[31]}}, x};
                py = {{32{y[31]}}, y};
                return px * py;
            end
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sx = x;
                sy = y;
                return {32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] mop, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = mop;
        a     = x;
        b     = y;
        sb.push_back(model(mop, x, y));
    endtask

    task automatic wait_done(output bit ok, output int busy_cycles);
        ok = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            if (done) begin
                ok = 1;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        hilo_sel = 1'b0;
        #1 l = result;
        hilo_sel = 1'b1;
        #1 h = result;
        hilo_sel = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
            n_fail++;
        end
        hilo_sel = 1'b1;
        #1;
        n_checks++;
        if (result !== 32'd0) begin
            $display("[TB] FAIL reset_hi got %h required 00000000", result);
            n_fail++;
        end
        hilo_sel = 1'b0;
        #1;
        n_checks++;
        if (result !== 32'd0) begin
            $display("[TB] FAIL reset_lo got %h required 00000000", result);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu_latency();
        bit ok;
        int bc;
        logic [31:0] h, l;
        logic [63:0] exp;
        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(ok, bc);
        exp = sb.pop_front();
        read_hilo(h, l);
        n_checks++;
        if (!ok) begin
            $display("[TB] FAIL multu_done no done pulse within bound");
            n_fail++;
        end
        n_checks++;
        if (bc !== 33) begin
            $display("[TB] FAIL multu_busy_cycles got %0d required 33", bc);
            n_fail++;
        end
        n_checks++;
        if ({h, l} !== exp) begin
            $display("[TB] FAIL multu_result got %h_%h required %h", h, l, exp);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            $display("[TB] FAIL done_width done still %b one cycle later, required 0", done);
            n_fail++;
        end
    endtask

    task automatic test_directed();
        bit ok;
        int bc;
        logic [31:0] h, l;
        logic [63:0] exp;
        logic [1:0]  ops[4]  = '{2'd1, 2'd3, 2'd3, 2'd2};
        logic [31:0] as_[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
        logic [31:0] bs_[4]  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            launch(ops[i], as_[i], bs_[i]);
            wait_done(ok, bc);
            exp = sb.pop_front();
            read_hilo(h, l);
            n_checks++;
            if (!ok || bc !== 33) begin
                $display("[TB] FAIL directed%0d_latency done=%0d busy_cycles=%0d required 1 33", i, ok, bc);
                n_fail++;
            end
            n_checks++;
            if ({h, l} !== exp) begin
                $display("[TB] FAIL directed%0d_result op=%0d got %h_%h required %h", i, ops[i], h, l, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        logic [31:0] h, l;
        logic [63:0] exp;
        ok = 0;
        launch(2'd0, 32'd3, 32'd5);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            if (done) begin
                ok = 1;
                break;
            end
            if (i == 10) begin
                start = 1'b1;
                op    = 2'd2;
                mthi  = 1'b1;
                mtlo  = 1'b1;
                a     = 32'hDEAD_BEEF;
                b     = 32'd9;
            end
        end
        exp = sb.pop_front();
        read_hilo(h, l);
        n_checks++;
        if (!ok || {h, l} !== exp) begin
            $display("[TB] FAIL ignore_busy done=%0d got %h_%h required %h", ok, h, l, exp);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            $display("[TB] FAIL ignore_busy_start busy=%b after done, required 0", busy);
            n_fail++;
        end
        mtlo = 1'b1;
        a    = 32'h0000_1234;
        @(negedge clk);
        mtlo = 1'b0;
        read_hilo(h, l);
        n_checks++;
        if (l !== 32'h0000_1234 || h !== 32'd0) begin
            $display("[TB] FAIL mtlo got hi=%h lo=%h required 00000000 00001234", h, l);
            n_fail++;
        end
        mthi = 1'b1;
        mtlo = 1'b1;
        start = 1'b1;
        op = 2'd0;
        a = 32'd2;
        b = 32'd4;
        sb.push_back(model(2'd0, 32'd2, 32'd4));
        wait_done(ok, l);
        exp = sb.pop_front();
        read_hilo(h, l);
        n_checks++;
        if (!ok || {h, l} !== exp) begin
            $display("[TB] FAIL start_beats_move got %h_%h required %h", h, l, exp);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        int bc;
        logic [31:0] h, l;
        logic [63:0] exp;
        launch(2'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done(ok1, bc);
        start = 1'b1;
        op    = 2'd2;
        a     = 32'hFFFF_FFFF;
        b     = 32'd10;
        sb.push_back(model(2'd2, 32'hFFFF_FFFF, 32'd10));
        exp = sb.pop_front();
        read_hilo(h, l);
        n_checks++;
        if (!ok1 || {h, l} !== exp) begin
            $display("[TB] FAIL b2b_first got %h_%h required %h", h, l, exp);
            n_fail++;
        end
        wait_done(ok2, bc);
        exp = sb.pop_front();
        read_hilo(h, l);
        n_checks++;
        if (!ok2 || bc !== 33 || {h, l} !== exp) begin
            $display("[TB] FAIL b2b_second done=%0d busy_cycles=%0d got %h_%h required 33 %h", ok2, bc, h, l, exp);
            n_fail++;
        end
    endtask

    task automatic test_random();
        bit ok;
        int bc;
        logic [31:0] h, l, x, y;
        logic [1:0]  mop;
        logic [63:0] exp;
        for (int i = 0; i < 12; i++) begin
            mop = 2'(i % 4);
            x = $urandom;
            y = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            launch(mop, x, y);
            wait_done(ok, bc);
            exp = sb.pop_front();
            read_hilo(h, l);
            n_checks++;
            if (!ok || {h, l} !== exp) begin
                $display("[TB] FAIL random%0d op=%0d a=%h b=%h got %h_%h required %h", i, mop, x, y, h, l, exp);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw_done;
        int bc;
        logic [31:0] h, l;
        logic [63:0] exp;
        launch(2'd3, 32'hFFFF_F000, 32'd17);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL midreset_flags busy=%b done=%b required 0 0", busy, done);
            n_fail++;
        end
        read_hilo(h, l);
        n_checks++;
        if (h !== 32'd0 || l !== 32'd0) begin
            $display("[TB] FAIL midreset_hilo got %h_%h required 0_0", h, l);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            $display("[TB] FAIL midreset_no_done aborted op still produced activity");
            n_fail++;
        end
        launch(2'd3, 32'd1000, 32'hFFFF_FFF9);
        wait_done(ok, bc);
        exp = sb.pop_front();
        read_hilo(h, l);
        n_checks++;
        if (!ok || bc !== 33 || {h, l} !== exp) begin
            $display("[TB] FAIL midreset_recover busy_cycles=%0d got %h_%h required 33 %h", bc, h, l, exp);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        a        = 32'd0;
        b        = 32'd0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        hilo_sel = 1'b0;
        test_reset();
        test_multu_latency();
        test_directed();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
